// File: rtl/riscv_wb_pkg.sv
// Shared types and helpers for the integer register file writeback front end.
//   wb_req_t   : one register write (destination + data)
//   NUM_WORDS  : number of architectural registers
//   ptr_width  : pointer width for a power-of-two FIFO depth
package riscv_wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int NUM_WORDS = 2 ** WB_ADDR_W;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_req_t;

  function automatic int ptr_width(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/riscv_wb_fifo.sv
// Small synchronous FIFO of wb_req_t holding load writebacks.
//   push/wdata : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, valid while !empty
//   full/empty/count : occupancy, all from registered state
module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_req_t                    wdata,
  input  logic                       pop,
  output wb_req_t                    rdata,
  output logic                       full,
  output logic                       empty,
  output logic [ptr_width(DEPTH):0]  count
);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/riscv_wb_arbiter.sv
// Write-side front end of the integer register file.
//   ex_*        : execute results, no backpressure, written on port a one cycle later
//   lsu_issue_* : load issue, marks destination busy
//   lsu_*       : load data via valid/ready into a FIFO, written on port b
//   waddr/wdata/we_{a,b}_o : register file write ports
//   busy_o      : outstanding load destinations
//   collide_o   : pulse when a load write is dropped in favour of an execute write
//   idle_o      : nothing buffered, nothing pending
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_W,
  parameter int DATA_WIDTH     = WB_DATA_W,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]      ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]      ex_wdata_i,
  input  logic                       lsu_issue_i,
  input  logic [ADDR_WIDTH-1:0]      lsu_issue_addr_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic                       we_b_o,
  output logic [2**ADDR_WIDTH-1:0]   busy_o,
  output logic                       collide_o,
  output logic                       idle_o
);
  localparam int NW = 2 ** ADDR_WIDTH;

  // Execute stage register; its contents drive port a directly.
  wb_req_t ex_q;
  logic    ex_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld_q <= 1'b0;
      ex_q     <= '0;
    end else begin
      ex_vld_q <= ex_valid_i;
      ex_q     <= '{waddr: ex_waddr_i, wdata: ex_wdata_i};
    end
  end

  assign waddr_a_o = ex_q.waddr;
  assign wdata_a_o = ex_q.wdata;
  assign we_a_o    = ex_vld_q && (ex_q.waddr != '0);

  // Load writeback buffer.
  wb_req_t                       head;
  logic                          fifo_full, fifo_empty;
  logic [ptr_width(LSU_FIFO_DEPTH):0] fifo_count;
  logic                          head_fire;

  // Debug hold on the FIFO head; tied off in silicon, lets a bench stall port b.
  logic hold_pop;
  assign hold_pop = 1'b0;

  riscv_wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsu_valid_i),
    .wdata ('{waddr: lsu_waddr_i, wdata: lsu_wdata_i}),
    .pop   (head_fire),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign lsu_ready_o = !fifo_full;
  assign head_fire   = !fifo_empty && !hold_pop;

  // The register file favours port b, so an older load targeting the same
  // register as the execute write must be dropped here.
  assign collide_o = head_fire && ex_vld_q && (head.waddr == ex_q.waddr) &&
                     (head.waddr != '0);
  assign we_b_o    = head_fire && (head.waddr != '0) && !collide_o;
  assign waddr_b_o = head_fire ? head.waddr : '0;
  assign wdata_b_o = head_fire ? head.wdata : '0;

  // Busy scoreboard: a popped head (written or discarded) clears its bit;
  // a new issue in the same cycle wins.
  logic [NW-1:0] busy_q, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (lsu_issue_i) set_mask[lsu_issue_addr_i] = 1'b1;
    if (head_fire)   clr_mask[head.waddr]       = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign busy_o = busy_q;
  assign idle_o = fifo_empty && !ex_vld_q && (busy_q == '0);

  a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
    (lsu_issue_i && lsu_issue_addr_i != '0) |-> !busy_q[lsu_issue_addr_i]);

  logic unused_count;
  assign unused_count = ^fifo_count;
endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Write-side front end of the integer register file; the only block that drives its two write ports (W1 = port a, W2 = port b).
- Merges two writeback sources:
  - execute-stage results (ALU/MUL/DIV), always accepted;
  - load results from the LSU, buffered in a small FIFO behind a valid/ready handshake.
- Keeps a per-register busy scoreboard of outstanding load destinations, which the decoder uses for RAW/WAW stalls.

Parameters:
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- LSU_FIFO_DEPTH, 2, load writeback buffer entries; legal values 2 or 4 (power of two).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid_i  in  1  execute result valid this cycle; no backpressure.
- ex_waddr_i  in  ADDR_WIDTH  execute destination register.
- ex_wdata_i  in  DATA_WIDTH  execute result.
- lsu_issue_i  in  1  load issued to memory this cycle; marks its destination busy.
- lsu_issue_addr_i  in  ADDR_WIDTH  destination of the issued load.
- lsu_valid_i  in  1  load data valid.
- lsu_ready_o  out  1  FIFO can accept load data.
- lsu_waddr_i  in  ADDR_WIDTH  load destination register.
- lsu_wdata_i  in  DATA_WIDTH  load data.
- waddr_a_o  out  ADDR_WIDTH  register file write port a address.
- wdata_a_o  out  DATA_WIDTH  write port a data.
- we_a_o  out  1  write port a enable.
- waddr_b_o  out  ADDR_WIDTH  write port b address.
- wdata_b_o  out  DATA_WIDTH  write port b data.
- we_b_o  out  1  write port b enable.
- busy_o  out  NUM_WORDS  bit i set means register i has an outstanding load.
- collide_o  out  1  one-cycle pulse: a load write was discarded due to an address collision.
- idle_o  out  1  FIFO empty, execute stage empty, busy_o all zero.

Behaviour:
- Reset (asynchronous, rst=1):
  - execute stage register, FIFO pointers/count and busy vector cleared;
  - we_a_o=0, we_b_o=0, collide_o=0, lsu_ready_o=1, idle_o=1, busy_o=0;
  - waddr_*/wdata_* outputs 0.
  - Reset mid-operation discards all buffered loads; no partial write is emitted.
- Execute path:
  - ex_valid_i sampled at cycle N appears on port a at N+1: we_a_o=1, waddr_a_o and wdata_a_o from the stage register.
  - Destination 0: we_a_o forced 0.
  - All port outputs are registered; no input-to-output combinational path.
- Load path:
  - Accept when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = (count != LSU_FIFO_DEPTH), computed from the registered count only. A full FIFO deasserts ready even in a cycle where it pops.
  - Entry accepted at N drives port b at N+1 at the earliest (FIFO head registered). One pop per cycle whenever the head is valid.
  - Entries with destination 0 pop with we_b_o=0.
  - Pointers wrap modulo LSU_FIFO_DEPTH; count width is clog2(LSU_FIFO_DEPTH)+1.
  - Simultaneous push and pop leaves count unchanged.
- Collision:
  - Condition: head valid, execute stage valid, both addresses equal and nonzero.
  - The load is older and the execute write wins: we_b_o=0, head popped, busy bit cleared, collide_o=1 for that cycle.
  - Needed because the register file gives port b priority.
  - Can only occur if the decoder WAW stall is bypassed; the behaviour is still mandatory.
- Scoreboard:
  - lsu_issue_i with a nonzero address sets busy[addr] at the next edge.
  - A port b write or collision discard of addr clears busy[addr] at the same edge the write is presented.
  - Set and clear of the same bit in one cycle: set wins.
  - busy[0] is constant 0.
  - Issue to an already-busy register is a protocol violation, covered by an assertion; behaviour is set-wins.
- No flush input: anything entering this block is committed.

Decomposition:
- Shared package riscv_wb_pkg:
  - typedef wb_req_t {waddr, wdata};
  - localparam NUM_WORDS;
  - function for FIFO pointer width.
- Sub-module riscv_wb_fifo: parameterised synchronous FIFO of wb_req_t with push/pop/full/empty/count.
- Arbiter top: stage register, collision logic, scoreboard, output registers.

Test Plan:
- Reset then ex_valid_i=1, ex_waddr_i=5, ex_wdata_i=0xDEADBEEF at cycle 1 -> cycle 2: we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF; cycle 3: we_a_o=0.
- lsu_issue_i addr 7, then load 7/0x1234 accepted 3 cycles later -> busy_o[7]=1 from the issue edge until the we_b_o=1 cycle (waddr_b_o=7, wdata_b_o=0x1234); busy_o[7]=0 after.
- Hold lsu_valid_i=1 for 4 cycles with port b stalled is impossible, so use back-to-back pushes -> lsu_ready_o never drops, since a pop occurs every cycle. Check FIFO fill separately via a forced-stall bench hook: with DEPTH=2, the third beat is refused and lsu_ready_o=0.
- Same cycle: execute stage writes reg 3 = 0xA, load head targets reg 3 = 0xB -> we_a_o=1 (0xA), we_b_o=0, collide_o=1 for one cycle, busy_o[3] cleared.
- Writes to register 0 on both paths -> we_a_o=we_b_o=0, busy_o[0]=0, FIFO still drains (idle_o returns to 1).
- Assert rst with 2 entries buffered and 2 busy bits set -> immediately busy_o=0, we_b_o=0, lsu_ready_o=1, idle_o=1; no buffered entry appears after release.
